text_scanout: RTL and testbench
===============================

// Module: text_scanout
// PURPOSE
//   Read side of the 80x25 text buffer written by the keyboard/console writer.
//   Generates 640x480@60 VGA timing from a pixel-clock enable.
//   Fetches character codes from the text RAM read port and looks each up in an external 8x16 font ROM.
//   Serialises glyph bits to a 1-bit pixel stream, with hsync/vsync/de aligned to the pixels.
// PARAMETERS
//   COLS      80   text columns; 640/CHAR_W
//   ROWS      25   text rows; rows*CHAR_H = 400 lines shown, lines 400..479 blank
//   CHAR_W     8   glyph width in pixels (fixed; shift register width)
//   CHAR_H    16   glyph height in lines
//   H_VIS/H_FP/H_SYNC/H_BP  640/16/96/48   horizontal timing; H_TOTAL=800
//   V_VIS/V_FP/V_SYNC/V_BP  480/10/2/33    vertical timing; V_TOTAL=525
// PORTS
//   clk        in   1   system clock
//   rst_n      in   1   asynchronous active-low reset
//   pix_ce     in   1   pixel-clock enable; all state advances only when high
//   vrx        out  7   text RAM read column
//   vry        out  5   text RAM read row
//   vrd        in   9   text RAM read data; valid 1 clk after vrx/vry change; [8]=reverse video, [7:0]=code
//   font_addr  out 12   {code[7:0], glyph line[3:0]}
//   font_data  in   8   glyph row, valid 1 clk after font_addr; bit 7 = leftmost pixel
//   cur_x      in   7   cursor column (used only with CURSOR_EN)
//   cur_y      in   5   cursor row (used only with CURSOR_EN)
//   hsync      out  1   horizontal sync, active low
//   vsync      out  1   vertical sync, active low
//   de         out  1   display enable (inside 640x400 text area)
//   pix        out  1   pixel value, 1 = foreground
//   frame      out  1   one-ce pulse at start of each frame (hc=0, vc=0)
// BEHAVIOUR
//   - Reset: hc=vc=0, vrx=vry=0, font_addr=0, hsync=vsync=1, de=0, pix=0, frame=0. Reset mid-line restarts at hc=vc=0.
//   - Counters: hc counts 0..799 on pix_ce and wraps to 0; vc increments on hc wrap, 0..524, then wraps to 0.
//   - Fetch pipeline: the pipeline advances one stage per pix_ce, so vrd and font_data must settle within one ce period.
//       - ce tick T (hc[2:0]==0, hc<640, vc<400): vrx<=hc[9:3], vry<=vc[8:4].
//       - T+1: font_addr<={vrd[7:0],vc[3:0]}, attr<=vrd[8].
//       - T+2: shift register <= font_data ^ {8{attr}}.
//       - T+2..T+9: pix = shift MSB; shift left each ce.
//   - Alignment: hsync, vsync and de are delayed 2 ce ticks, so they are aligned with pix.
//   - Total latency from counter position to pix: 2 ce ticks.
//   - Outside the text area (hc>=640 or vc>=400): de=0, pix=0. vrx/vry hold their last value.
//   - No fetch is issued for hc>=640, so the fetch address never exceeds COLS-1 or ROWS-1.
//   - Sync windows: hsync low for hc in 656..751; vsync low for vc in 490..491.
//   - frame: high for exactly one ce period, aligned with the pixel at (0,0).
//   - pix_ce low: all registers hold. Outputs are stable between enables.
// CONFIGURATION
//   CURSOR_EN defined:
//     - An 8-bit frame counter runs, incremented on each frame pulse.
//     - When blink=framecnt[4], glyph lines 14..15 of cell (cur_x,cur_y) are forced to 8'hFF before the attr XOR.
//     - Blink period is 32 frames, 16 on and 16 off.
//     - Cursor coordinates are sampled at the fetch tick T.
//   CURSOR_EN undefined: no frame counter; cur_x and cur_y are ignored. Output is identical to CURSOR_EN defined with blink=0.
// STRUCTURE
//   Package video_pkg:
//     - COLS, ROWS, CHAR_W, CHAR_H.
//     - The H_*/V_* timing constants and the derived H_TOTAL/V_TOTAL.
//     - The 9-bit character cell typedef {attr, code}, shared with the buffer writer.
//   Sub-module vga_timing:
//     - Owns hc/vc, raw hsync/vsync/de and frame.
//     - text_scanout instantiates it and adds the fetch pipeline and delay alignment.
// TESTING
//   1. Reset, then free-run pix_ce=1 for one frame.
//      -> frame period 420000 clk; hsync low 96 ce per line; vsync low for 2 lines starting at line 490.
//   2. RAM model with cell(0,0)=9'h041 and font 'A' line 0 = 8'h18.
//      -> pix pattern 00011000 on line 0, hc 0..7, aligned with de rising.
//   3. cell(79,24)=9'h141, attr set.
//      -> pixels at hc 632..639, vc 384 equal ~8'h18 = 11100111; de falls at hc 640.
//   4. Assert rst_n low at hc=300, vc=200 for 3 clk.
//      -> hsync=vsync=1, pix=0, de=0 immediately; after release hc restarts at 0 and the next frame pulse is 420000 ce later.
//   5. pix_ce=1 every 4th clk.
//      -> same pixel sequence as test 2, with outputs held constant across the non-enabled clocks.
//   6. CURSOR_EN, cur=(5,3), blank RAM.
//      -> pix=1 at hc 40..47 on lines 62..63 during frames 16..31; pix=0 there during frames 0..15.

Source files
------------

// File: rtl/video_pkg.sv
// ---------------------------------------------------------------------------
// video_pkg
//   Shared constants and types for the text-mode video path.
//   - CHAR_W/CHAR_H glyph geometry, COLS/ROWS text grid
//   - 640x480@60 horizontal/vertical timing and derived totals
//   - cell_t: one text buffer entry {attr, code}, shared with the buffer writer
//   - in_window(): counter range decode used for the sync pulses
//   - glyph_row(): final glyph row after cursor force and reverse video
// ---------------------------------------------------------------------------
package video_pkg;

   localparam int CHAR_W  = 8;
   localparam int CHAR_H  = 16;

   localparam int H_VIS   = 640;
   localparam int H_FP    = 16;
   localparam int H_SYNC  = 96;
   localparam int H_BP    = 48;
   localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

   localparam int V_VIS   = 480;
   localparam int V_FP    = 10;
   localparam int V_SYNC  = 2;
   localparam int V_BP    = 33;
   localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

   localparam int COLS    = H_VIS / CHAR_W;
   localparam int ROWS    = 25;

   // Width of the beam counters; wide enough for H_TOTAL and V_TOTAL.
   localparam int CNT_W   = 10;

   typedef struct packed {
      logic       attr;
      logic [7:0] code;
   } cell_t;

   function automatic logic in_window(input logic [CNT_W-1:0] cnt,
                                      input int lo, input int len);
      return (int'(cnt) >= lo) && (int'(cnt) < lo + len);
   endfunction

   function automatic logic [CHAR_W-1:0] glyph_row(input logic [CHAR_W-1:0] bits,
                                                   input logic attr,
                                                   input logic force_on);
      logic [CHAR_W-1:0] row;
      row = force_on ? {CHAR_W{1'b1}} : bits;
      return row ^ {CHAR_W{attr}};
   endfunction

endpackage

// File: rtl/vga_timing.sv
// ---------------------------------------------------------------------------
// vga_timing
//   Beam counters and raw (undelayed) timing decodes for the text display.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     pix_ce          pixel-clock enable; counters advance only when high
//     hc, vc          current beam column / line
//     hsync_raw       active-low horizontal sync for the current hc
//     vsync_raw       active-low vertical sync for the current vc
//     de_raw          beam is inside the text area (hc < H_VIS, vc < TXT_LINES)
//     frame_raw       beam is at (0,0)
//     frame_end       beam is at the last position of the frame
// ---------------------------------------------------------------------------
module vga_timing
   import video_pkg::*;
#(
   parameter int H_VIS     = video_pkg::H_VIS,
   parameter int H_FP      = video_pkg::H_FP,
   parameter int H_SYNC    = video_pkg::H_SYNC,
   parameter int H_BP      = video_pkg::H_BP,
   parameter int V_VIS     = video_pkg::V_VIS,
   parameter int V_FP      = video_pkg::V_FP,
   parameter int V_SYNC    = video_pkg::V_SYNC,
   parameter int V_BP      = video_pkg::V_BP,
   parameter int TXT_LINES = video_pkg::ROWS * video_pkg::CHAR_H
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pix_ce,
   output logic [CNT_W-1:0] hc,
   output logic [CNT_W-1:0] vc,
   output logic             hsync_raw,
   output logic             vsync_raw,
   output logic             de_raw,
   output logic             frame_raw,
   output logic             frame_end
);

   localparam logic [CNT_W-1:0] HC_LAST = CNT_W'(H_VIS + H_FP + H_SYNC + H_BP - 1);
   localparam logic [CNT_W-1:0] VC_LAST = CNT_W'(V_VIS + V_FP + V_SYNC + V_BP - 1);

   logic [CNT_W-1:0] hc_q, hc_d;
   logic [CNT_W-1:0] vc_q, vc_d;
   logic             hc_wrap;

   assign hc_wrap = (hc_q == HC_LAST);

   always_comb begin
      hc_d = hc_q;
      vc_d = vc_q;
      if (pix_ce) begin
         if (hc_wrap) begin
            hc_d = '0;
            vc_d = (vc_q == VC_LAST) ? '0 : vc_q + 1'b1;
         end else begin
            hc_d = hc_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hc_q <= '0;
         vc_q <= '0;
      end else begin
         hc_q <= hc_d;
         vc_q <= vc_d;
      end
   end

   assign hc        = hc_q;
   assign vc        = vc_q;
   assign de_raw    = (hc_q < CNT_W'(H_VIS)) && (vc_q < CNT_W'(TXT_LINES));
   assign hsync_raw = ~in_window(hc_q, H_VIS + H_FP, H_SYNC);
   assign vsync_raw = ~in_window(vc_q, V_VIS + V_FP, V_SYNC);
   assign frame_raw = (hc_q == '0) && (vc_q == '0);
   assign frame_end = hc_wrap && (vc_q == VC_LAST);

endmodule

// File: rtl/text_scanout.sv
// ---------------------------------------------------------------------------
// text_scanout
//   Read side of the text buffer: VGA timing, character fetch, font lookup
//   and glyph serialisation to a 1-bit pixel stream.
//   Optional feature: define CURSOR_EN for a blinking underline cursor.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     pix_ce          pixel-clock enable; all state advances only when high
//     vrx, vry        text RAM read column / row (registered)
//     vrd             text RAM data {attr, code}, combinational from vrx/vry
//     font_addr       {code, glyph line} to the external font ROM (registered)
//     font_data       glyph row from the font ROM, bit 7 = leftmost pixel
//     cur_x, cur_y    cursor cell (only used with CURSOR_EN)
//     hsync, vsync    active-low syncs, aligned with pix
//     de              display enable for the text area, aligned with pix
//     pix             pixel, 1 = foreground
//     frame           one-ce pulse with the pixel at (0,0)
//   Latency: a beam position appears on the outputs two enables after the
//   enable that consumed it (fetch -> font lookup -> shift load).
// ---------------------------------------------------------------------------
module text_scanout
   import video_pkg::*;
#(
   parameter int H_VIS  = video_pkg::H_VIS,
   parameter int H_FP   = video_pkg::H_FP,
   parameter int H_SYNC = video_pkg::H_SYNC,
   parameter int H_BP   = video_pkg::H_BP,
   parameter int V_VIS  = video_pkg::V_VIS,
   parameter int V_FP   = video_pkg::V_FP,
   parameter int V_SYNC = video_pkg::V_SYNC,
   parameter int V_BP   = video_pkg::V_BP,
   parameter int ROWS   = video_pkg::ROWS
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pix_ce,
   output logic [6:0]  vrx,
   output logic [4:0]  vry,
   input  logic [8:0]  vrd,
   output logic [11:0] font_addr,
   input  logic [7:0]  font_data,
   input  logic [6:0]  cur_x,
   input  logic [4:0]  cur_y,
   output logic        hsync,
   output logic        vsync,
   output logic        de,
   output logic        pix,
   output logic        frame
);

   localparam int TXT_LINES = ROWS * CHAR_H;

   logic [CNT_W-1:0] hc, vc;
   logic             hsync_raw, vsync_raw, de_raw, frame_raw, frame_end;

   vga_timing #(
      .H_VIS     (H_VIS),
      .H_FP      (H_FP),
      .H_SYNC    (H_SYNC),
      .H_BP      (H_BP),
      .V_VIS     (V_VIS),
      .V_FP      (V_FP),
      .V_SYNC    (V_SYNC),
      .V_BP      (V_BP),
      .TXT_LINES (TXT_LINES)
   ) u_timing (
      .clk       (clk),
      .rst_n     (rst_n),
      .pix_ce    (pix_ce),
      .hc        (hc),
      .vc        (vc),
      .hsync_raw (hsync_raw),
      .vsync_raw (vsync_raw),
      .de_raw    (de_raw),
      .frame_raw (frame_raw),
      .frame_end (frame_end)
   );

   cell_t cell_in;
   logic  fetch;
   logic  cur_hit;

   assign cell_in = cell_t'(vrd);
   // One fetch per character cell, only inside the text area, so the read
   // address never leaves the COLS x ROWS grid.
   assign fetch   = pix_ce && de_raw && (hc[2:0] == 3'd0);

`ifdef CURSOR_EN
   logic [7:0] framecnt_q, framecnt_d;
   logic       blink;
   logic       unused_bits;

   // Counting at the last beam position makes the count equal the index of
   // the frame being scanned (frame 0 follows reset).
   always_comb begin
      framecnt_d = framecnt_q;
      if (pix_ce && frame_end) framecnt_d = framecnt_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) framecnt_q <= '0;
      else        framecnt_q <= framecnt_d;
   end

   assign blink       = framecnt_q[4];
   assign cur_hit     = blink && (hc[9:3] == cur_x) && (vc[8:4] == cur_y);
   assign unused_bits = vc[9];
`else
   logic unused_bits;
   assign cur_hit     = 1'b0;
   assign unused_bits = ^{cur_x, cur_y, frame_end, vc[9]};
`endif

   // p1: read address and control captured at the fetch enable
   logic [6:0]  vrx_q, vrx_d;
   logic [4:0]  vry_q, vry_d;
   logic [3:0]  line_p1_q, line_p1_d;
   logic        ld_p1_q, ld_p1_d;
   logic        cur_p1_q, cur_p1_d;
   logic        hs_p1_q, hs_p1_d, vs_p1_q, vs_p1_d;
   logic        de_p1_q, de_p1_d, fr_p1_q, fr_p1_d;
   // p2: font address built from the returned cell
   logic [11:0] font_addr_q, font_addr_d;
   logic        attr_p2_q, attr_p2_d;
   logic        ld_p2_q, ld_p2_d;
   logic        cur_p2_q, cur_p2_d;
   logic        hs_p2_q, hs_p2_d, vs_p2_q, vs_p2_d;
   logic        de_p2_q, de_p2_d, fr_p2_q, fr_p2_d;
   // p3: pixel shifter and aligned timing outputs
   logic [7:0]  shift_q, shift_d;
   logic        hsync_q, hsync_d, vsync_q, vsync_d;
   logic        de_q, de_d, frame_q, frame_d;

   always_comb begin
      vrx_d       = vrx_q;
      vry_d       = vry_q;
      line_p1_d   = line_p1_q;
      ld_p1_d     = ld_p1_q;
      cur_p1_d    = cur_p1_q;
      hs_p1_d     = hs_p1_q;
      vs_p1_d     = vs_p1_q;
      de_p1_d     = de_p1_q;
      fr_p1_d     = fr_p1_q;
      font_addr_d = font_addr_q;
      attr_p2_d   = attr_p2_q;
      ld_p2_d     = ld_p2_q;
      cur_p2_d    = cur_p2_q;
      hs_p2_d     = hs_p2_q;
      vs_p2_d     = vs_p2_q;
      de_p2_d     = de_p2_q;
      fr_p2_d     = fr_p2_q;
      shift_d     = shift_q;
      hsync_d     = hsync_q;
      vsync_d     = vsync_q;
      de_d        = de_q;
      frame_d     = frame_q;

      if (pix_ce) begin
         // p0 -> p1
         ld_p1_d = fetch;
         if (fetch) begin
            vrx_d     = hc[9:3];
            vry_d     = vc[8:4];
            line_p1_d = vc[3:0];
            cur_p1_d  = cur_hit;
         end
         hs_p1_d = hsync_raw;
         vs_p1_d = vsync_raw;
         de_p1_d = de_raw;
         fr_p1_d = frame_raw;

         // p1 -> p2
         ld_p2_d = ld_p1_q;
         if (ld_p1_q) begin
            font_addr_d = {cell_in.code, line_p1_q};
            attr_p2_d   = cell_in.attr;
            // Underline cursor occupies the bottom two glyph lines.
            cur_p2_d    = cur_p1_q && (line_p1_q >= 4'd14);
         end
         hs_p2_d = hs_p1_q;
         vs_p2_d = vs_p1_q;
         de_p2_d = de_p1_q;
         fr_p2_d = fr_p1_q;

         // p2 -> p3: zeros shift in, so the area after the last cell is blank
         shift_d = ld_p2_q ? glyph_row(font_data, attr_p2_q, cur_p2_q)
                           : {shift_q[6:0], 1'b0};
         hsync_d = hs_p2_q;
         vsync_d = vs_p2_q;
         de_d    = de_p2_q;
         frame_d = fr_p2_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vrx_q       <= '0;
         vry_q       <= '0;
         line_p1_q   <= '0;
         ld_p1_q     <= 1'b0;
         cur_p1_q    <= 1'b0;
         hs_p1_q     <= 1'b1;
         vs_p1_q     <= 1'b1;
         de_p1_q     <= 1'b0;
         fr_p1_q     <= 1'b0;
         font_addr_q <= '0;
         attr_p2_q   <= 1'b0;
         ld_p2_q     <= 1'b0;
         cur_p2_q    <= 1'b0;
         hs_p2_q     <= 1'b1;
         vs_p2_q     <= 1'b1;
         de_p2_q     <= 1'b0;
         fr_p2_q     <= 1'b0;
         shift_q     <= '0;
         hsync_q     <= 1'b1;
         vsync_q     <= 1'b1;
         de_q        <= 1'b0;
         frame_q     <= 1'b0;
      end else begin
         vrx_q       <= vrx_d;
         vry_q       <= vry_d;
         line_p1_q   <= line_p1_d;
         ld_p1_q     <= ld_p1_d;
         cur_p1_q    <= cur_p1_d;
         hs_p1_q     <= hs_p1_d;
         vs_p1_q     <= vs_p1_d;
         de_p1_q     <= de_p1_d;
         fr_p1_q     <= fr_p1_d;
         font_addr_q <= font_addr_d;
         attr_p2_q   <= attr_p2_d;
         ld_p2_q     <= ld_p2_d;
         cur_p2_q    <= cur_p2_d;
         hs_p2_q     <= hs_p2_d;
         vs_p2_q     <= vs_p2_d;
         de_p2_q     <= de_p2_d;
         fr_p2_q     <= fr_p2_d;
         shift_q     <= shift_d;
         hsync_q     <= hsync_d;
         vsync_q     <= vsync_d;
         de_q        <= de_d;
         frame_q     <= frame_d;
      end
   end

   assign vrx       = vrx_q;
   assign vry       = vry_q;
   assign font_addr = font_addr_q;
   assign hsync     = hsync_q;
   assign vsync     = vsync_q;
   assign de        = de_q;
   assign pix       = shift_q[7] & de_q;
   assign frame     = frame_q;

endmodule

// File: tb/tb_text_scanout.sv
// ---------------------------------------------------------------------------
// tb_text_scanout
//   Scoreboard bench for text_scanout on a reduced raster (6x4 text cells,
//   56x72 total) so several whole frames fit in a short run.
//   Text RAM: cell(0,0)=9'h041, cell(COLS-1,ROWS-1)=9'h141, others 9'h000.
//   Font ROM: 'A' line 0 = 8'h18, everything else 8'h00.
//   With CURSOR_EN defined the cursor sits at cell (5,3).
// ---------------------------------------------------------------------------
module tb_text_scanout;

   localparam int HV = 48, HF = 2, HS = 4, HB = 2;
   localparam int VV = 66, VF = 2, VS = 2, VB = 2;
   localparam int HT = HV + HF + HS + HB;
   localparam int VT = VV + VF + VS + VB;
   localparam int NC = HV / 8;
   localparam int NR = 4;
   localparam int FR = HT * VT;

   logic        clk, rst_n, pix_ce;
   logic [6:0]  vrx;
   logic [4:0]  vry;
   logic [8:0]  vrd;
   logic [11:0] font_addr;
   logic [7:0]  font_data;
   logic [6:0]  cur_x;
   logic [4:0]  cur_y;
   logic        hsync, vsync, de, pix, frame;

   text_scanout #(
      .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .ROWS(NR)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
      .vrx(vrx), .vry(vry), .vrd(vrd),
      .font_addr(font_addr), .font_data(font_data),
      .cur_x(cur_x), .cur_y(cur_y),
      .hsync(hsync), .vsync(vsync), .de(de), .pix(pix), .frame(frame)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign cur_x = 7'd5;
   assign cur_y = 5'd3;

   always_comb begin
      vrd = 9'h000;
      if (vrx == 7'd0 && vry == 5'd0) vrd = 9'h041;
      else if (vrx == 7'(NC - 1) && vry == 5'(NR - 1)) vrd = 9'h141;
   end

   assign font_data = (font_addr == 12'h410) ? 8'h18 : 8'h00;

   int checks = 0;
   int failures = 0;
   bit exp_q[$];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   // Hand-derived pixel at text-area position (x,y).
   function automatic bit exp_pix(input int x, input int y, input bit blink);
      int col, row, line;
      logic [7:0] g;
      bit a;
      col  = x / 8;
      row  = y / 16;
      line = y % 16;
      g    = 8'h00;
      a    = 1'b0;
      if (col == 0 && row == 0 && line == 0) g = 8'h18;
      if (col == NC - 1 && row == NR - 1) begin
         a = 1'b1;
         if (line == 0) g = 8'h18;
      end
      if (blink && col == 5 && row == 3 && line >= 14) g = 8'hFF;
      if (a) g = ~g;
      return g[7 - (x % 8)];
   endfunction

   task automatic push_frame(input int fr);
      bit blink;
`ifdef CURSOR_EN
      blink = ((fr % 32) >= 16);
`else
      blink = (fr < 0);
`endif
      for (int y = 0; y < NR * 16; y++)
         for (int x = 0; x < HV; x++)
            exp_q.push_back(exp_pix(x, y, blink));
   endtask

   // Monitor: position model counts enables since reset release.
   int e = 0, cyc = 0, last_fr_cyc = -1, ce_div = 1;
   int pos, hx, vy;
   logic mon_ce, mon_rst;
   logic [28:0] outs, prev_outs;
   bit ep;

   assign outs = {hsync, vsync, de, pix, frame, vrx, vry, font_addr};

   always @(posedge clk) begin
      mon_ce  = pix_ce;
      mon_rst = rst_n;
      cyc++;
      #1;
      if (!mon_rst) begin
         e = 0;
         last_fr_cyc = -1;
         check("rst_hsync", hsync, 1);
         check("rst_vsync", vsync, 1);
         check("rst_de", de, 0);
         check("rst_pix", pix, 0);
         check("rst_frame", frame, 0);
         check("rst_vrx", vrx, 0);
         check("rst_vry", vry, 0);
         check("rst_font_addr", font_addr, 0);
      end else if (mon_ce) begin
         pos = e - 2;
         if (pos < 0) begin
            check("lat_hsync", hsync, 1);
            check("lat_vsync", vsync, 1);
            check("lat_de", de, 0);
            check("lat_pix", pix, 0);
            check("lat_frame", frame, 0);
         end else begin
            hx = pos % HT;
            vy = (pos / HT) % VT;
            check("de", de, int'(hx < HV && vy < NR * 16));
            check("hsync", hsync, int'(!(hx >= HV + HF && hx < HV + HF + HS)));
            check("vsync", vsync, int'(!(vy >= VV + VF && vy < VV + VF + VS)));
            check("frame", frame, int'(hx == 0 && vy == 0));
            if (frame) begin
               if (last_fr_cyc >= 0) check("frame_period", cyc - last_fr_cyc, FR * ce_div);
               last_fr_cyc = cyc;
            end
            if (de) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL pix_unexpected actual=%0d expected=none x=%0d y=%0d", pix, hx, vy);
               end else begin
                  ep = exp_q.pop_front();
                  check("pix", pix, ep);
               end
            end else begin
               check("pix_blank", pix, 0);
            end
         end
         check("vrx_range", int'(vrx < 7'(NC)), 1);
         check("vry_range", int'(vry < 5'(NR)), 1);
         e++;
      end else begin
         check("hold", outs, prev_outs);
      end
      prev_outs = outs;
   end

   int nfr;

   initial begin
      rst_n  = 1'b0;
      pix_ce = 1'b0;
      repeat (3) @(negedge clk);

      // Free-running enable: two full frames of timing and pixels.
      push_frame(0);
      push_frame(1);
      pix_ce = 1'b1;
      rst_n  = 1'b1;
      repeat (2 * FR + 2) @(negedge clk);
      check("queue_empty_run", exp_q.size(), 0);

      // Reset mid-frame at beam position hc=28 (output side), line 20.
      push_frame(2);
      repeat (20 * HT + 29) @(negedge clk);
      check("de_before_rst", de, 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_hsync", hsync, 1);
      check("async_rst_vsync", vsync, 1);
      check("async_rst_de", de, 0);
      check("async_rst_pix", pix, 0);
      repeat (3) @(negedge clk);
      exp_q.delete();
`ifdef CURSOR_EN
      nfr = 17;
`else
      nfr = 2;
`endif
      for (int f = 0; f < nfr; f++) push_frame(f);
      rst_n = 1'b1;
      repeat (nfr * FR + 2) @(negedge clk);
      check("queue_empty_after_rst", exp_q.size(), 0);

      // Enable on every 4th clock: first two lines must repeat the pattern.
      rst_n  = 1'b0;
      pix_ce = 1'b0;
      repeat (2) @(negedge clk);
      exp_q.delete();
      push_frame(0);
      ce_div = 4;
      rst_n  = 1'b1;
      for (int i = 0; i < (2 * HT + 2) * 4; i++) begin
         pix_ce = (i % 4 == 0);
         @(negedge clk);
      end
      pix_ce = 1'b0;
      repeat (4) @(negedge clk);
      check("queue_slow_ce", exp_q.size(), NR * 16 * HV - 2 * HV);
      exp_q.delete();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
